// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - E-stage multiply/divide sequencer owning HI/LO (optional MULDIV_DIV0_HOLD_EN)
// Operands latch on a valid start; the result lands in HI/LO when the busy down-counter expires.
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_sgn_a;
  logic        w_sgn_b;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_div_b;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_div0;

  assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_sgn_a = (r_op == 2'd2) && r_a[31];
  assign w_sgn_b = (r_op == 2'd2) && r_b[31];
  assign w_abs_a = w_sgn_a ? (~r_a + 32'd1) : r_a;
  assign w_abs_b = w_sgn_b ? (~r_b + 32'd1) : r_b;
  assign w_div0  = (r_b == 32'd0);
  assign w_div_b = w_div0 ? 32'd1 : w_abs_b;
  assign w_uq    = w_abs_a / w_div_b;
  assign w_ur    = w_abs_a % w_div_b;
  assign w_quo   = (w_sgn_a ^ w_sgn_b) ? (~w_uq + 32'd1) : w_uq;
  assign w_rem   = w_sgn_a ? (~w_ur + 32'd1) : w_ur;

  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign md_stall = d_is_md & ((start & ~r_busy) | r_busy);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_op    <= 2'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1: begin
                r_op    <= op[1:0];
                r_a     <= a;
                r_b     <= b;
                r_cnt   <= 4'(MULT_CYCLES);
                r_busy  <= 1'b1;
                r_state <= RUN;
              end
              3'd2, 3'd3: begin
`ifdef MULDIV_DIV0_HOLD_EN
                if (b != 32'd0) begin
                  r_op    <= op[1:0];
                  r_a     <= a;
                  r_b     <= b;
                  r_cnt   <= 4'(DIV_CYCLES);
                  r_busy  <= 1'b1;
                  r_state <= RUN;
                end
`else
                r_op    <= op[1:0];
                r_a     <= a;
                r_b     <= b;
                r_cnt   <= 4'(DIV_CYCLES);
                r_busy  <= 1'b1;
                r_state <= RUN;
`endif
              end
              3'd4:    r_hi <= a;
              3'd5:    r_lo <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (r_cnt == 4'd1) begin
            case (r_op)
              2'd0: {r_hi, r_lo} <= w_prod_s;
              2'd1: {r_hi, r_lo} <= w_prod_u;
              default: begin
                if (w_div0) begin
                  r_hi <= r_a;
                  r_lo <= 32'hFFFF_FFFF;
                end else begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
                end
              end
            endcase
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed bench for muldiv_ctrl (honours MULDIV_DIV0_HOLD_EN)
module tb_muldiv_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_is_md;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        md_stall;

  int n_vec = 0;
  int n_err = 0;
  int n_busy;

  muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .d_is_md(d_is_md), .busy(busy), .hi(hi), .lo(lo), .md_stall(md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts consecutive busy cycles, bounded so a stuck busy cannot hang the run.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd7; a = '0; b = '0; d_is_md = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, md_stall}, 32'd0);

    // mult -2 * 3
    start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFE; b = 32'd3; d_is_md = 1'b1;
    #1;
    chk("stall_on_start", {31'd0, md_stall}, 32'd1);
    step();
    start = 1'b0; a = 32'h5555_5555; b = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("mult_busy", {31'd0, busy}, 32'd1);
      if (i == 2) chk("mult_stall", {31'd0, md_stall}, 32'd1);
      step();
    end
    chk("mult_busy_end", {31'd0, busy}, 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    chk("stall_idle", {31'd0, md_stall}, 32'd0);
    d_is_md = 1'b0;

    // divu 7/2 with an mthi attempted while busy
    start = 1'b1; op = 3'd3; a = 32'd7; b = 32'd2;
    step();
    chk("divu_busy", {31'd0, busy}, 32'd1);
    op = 3'd4; a = 32'h1234;
    step();
    start = 1'b0;
    chk("ignored_mthi", hi, 32'hFFFF_FFFF);
    count_busy(n_busy);
    chk("divu_cycles", n_busy, 32'd9);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    // div -7/2
    start = 1'b1; op = 3'd2; a = 32'hFFFF_FFF9; b = 32'd2;
    step();
    start = 1'b0;
    count_busy(n_busy);
    chk("div_cycles", n_busy, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // signed overflow
    start = 1'b1; op = 3'd2; a = 32'h8000_0000; b = 32'hFFFF_FFFF;
    step();
    start = 1'b0;
    count_busy(n_busy);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

    // mthi then mtlo
    start = 1'b1; op = 3'd4; a = 32'hAA;
    step();
    chk("mthi_hi", hi, 32'hAA);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    op = 3'd5; a = 32'hBB;
    step();
    chk("mtlo_lo", lo, 32'hBB);
    chk("mtlo_hi", hi, 32'hAA);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);

    // op 6 is a no-op
    op = 3'd6; a = 32'hDEAD;
    step();
    start = 1'b0;
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_hi", hi, 32'hAA);
    chk("nop_lo", lo, 32'hBB);

    // multu interrupted by reset in the third busy cycle
    start = 1'b1; op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    for (int i = 0; i < 6; i++) step();
    chk("late_hi", hi, 32'h0);
    chk("late_lo", lo, 32'h0);

    // divu by zero
    start = 1'b1; op = 3'd4; a = 32'h55;
    step();
    op = 3'd3; a = 32'd9; b = 32'd0;
    step();
    start = 1'b0;
`ifdef MULDIV_DIV0_HOLD_EN
    chk("div0_busy", {31'd0, busy}, 32'd0);
    step();
    step();
    chk("div0_busy_later", {31'd0, busy}, 32'd0);
    chk("div0_hi", hi, 32'h55);
    chk("div0_lo", lo, 32'h0);
`else
    count_busy(n_busy);
    chk("div0_cycles", n_busy, 32'd10);
    chk("div0_hi", hi, 32'd9);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencing controller for the multiply/divide resource beside the ALU in the E stage.
- Captures operands on a start pulse and models the fixed multicycle latency with a down-counter.
- Owns the HI/LO registers that mfhi/mflo read back through the E-stage result select.
- Raises a stall request to the hazard unit while the resource is occupied.

Parameters:
MULT_CYCLES, 5, busy-cycle count for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy-cycle count for div/divu (legal range 1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  E-stage md instruction valid this cycle
op  input  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo; 6,7 = no-op
a  input  32  rs operand (forwarded)
b  input  32  rt operand (forwarded)
d_is_md  input  1  D-stage instruction is mult/div/mthi/mtlo/mfhi/mflo
busy  output  1  long operation in progress
hi  output  32  HI register
lo  output  32  LO register
md_stall  output  1  stall request = d_is_md & (start_valid | busy)

Behaviour:
- Reset values: busy=0, hi=0, lo=0, counter=0, operand latches=0.
- md_stall is combinational from the registered busy flag.
- start_valid = start & ~busy.
- reset dominates every other event in the same cycle.
- Start sampled at edge T with op 0..3:
  - Latch a, b and op.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from T+1.
- Counter:
  - Decrements each edge while nonzero.
  - On the edge where counter==1: write the result to HI/LO, counter goes to 0, busy goes to 0.
  - busy is therefore high for exactly N cycles; the new hi/lo is visible in the first cycle busy is low.
- mult: signed 64-bit product, {hi,lo} = product.
- multu: unsigned 64-bit product, {hi,lo} = product.
- div / divu:
  - lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed overflow 0x8000_0000 / 0xFFFF_FFFF gives lo=0x8000_0000, hi=0.
- mthi / mtlo:
  - Single-cycle write of a to hi / lo at the sampling edge.
  - busy is not asserted.
- start while busy=1: ignored entirely; no latch, no counter reload, no HI/LO write. The hazard unit guarantees this does not happen in normal flow.
- op 6/7 with start=1: no effect.
- Reset mid-operation: counter cleared, busy=0, hi=lo=0, pending result discarded.
- Results are computed from the latched operands, not the live a/b, so a/b may change freely while busy.
- State view:
  - IDLE (counter==0) -> RUN on a valid long op.
  - RUN -> IDLE on the edge where counter==1, with HI/LO written.

Optional Feature:
- Macro: MULDIV_DIV0_HOLD_EN
- Defined:
  - div/divu with b==0: hi/lo unchanged, busy never asserted, counter not loaded.
  - The instruction completes in 0 extra cycles.
- Not defined:
  - b==0 runs the full DIV_CYCLES latency.
  - Then writes hi=a (latched), lo=0xFFFF_FFFF for both div and divu.

Test Plan:
- reset=1 for 2 cycles, then 0 -> hi=0, lo=0, busy=0, md_stall=0.
- start, op=0, a=0xFFFF_FFFE (-2), b=3:
  - busy high exactly 5 cycles.
  - hi=0xFFFF_FFFF, lo=0xFFFF_FFFA in cycle 6 after start.
  - d_is_md=1 during busy -> md_stall=1.
- start, op=3, a=7, b=2, then start op=4 a=0x1234 while busy -> ignored.
  - After 10 busy cycles: lo=3, hi=1.
- start, op=2, a=0xFFFF_FFF9 (-7), b=2 -> after 10 cycles lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- start op=4 a=0xAA, next cycle start op=5 a=0xBB:
  - hi=0xAA then lo=0xBB on successive edges.
  - busy stays 0.
- start op=1, a=b=0xFFFF_FFFF, reset=1 on the 3rd busy cycle -> busy=0, hi=lo=0 next cycle; no late write.
- Div-by-zero, op=3, a=9, b=0:
  - Macro defined: busy stays 0, hi/lo unchanged.
  - Macro undefined: 10 busy cycles, then hi=9, lo=0xFFFF_FFFF.
